// File: rtl/spmv_row_mac.sv
// Sparse matrix x dense vector row engine: accumulates one row dot-product per
// stream of nonzeros against a latched input vector and hands each row result downstream.
module spmv_row_mac #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_ELEM = 16,
    localparam int unsigned IDX_W = $clog2(N_ELEM),
    localparam int unsigned CNT_W = IDX_W + 1,
    localparam int unsigned SUM_W = 2 * DATA_W + 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [N_ELEM*DATA_W-1:0] i_in_vector,
    input  logic [CNT_W-1:0]         i_num_rows,
    input  logic                     i_nnz_valid,
    output logic                     o_nnz_ready,
    input  logic [DATA_W-1:0]        i_mat_value,
    input  logic [IDX_W-1:0]         i_col_idx,
    input  logic                     i_row_last,
    output logic                     o_row_valid,
    input  logic                     i_row_ready,
    output logic [SUM_W-1:0]         o_row_sum,
    output logic [IDX_W-1:0]         o_row_idx,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAcc  = 2'd1;
    localparam logic [1:0] StOut  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [N_ELEM*DATA_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0]         rows_q, rows_d;
    logic [SUM_W-1:0]         acc_q, acc_d;
    logic [SUM_W-1:0]         sum_q, sum_d;
    logic [IDX_W-1:0]         idx_q, idx_d;

    logic [CNT_W-1:0]          eff_rows;
    logic [IDX_W-1:0]          last_idx;
    logic signed [DATA_W-1:0]  vec_el;
    logic signed [DATA_W-1:0]  mat_val;
    logic signed [2*DATA_W-1:0] prod;
    logic [SUM_W-1:0]          acc_sum;

    // Zero and anything above the buffer depth both mean a full-depth job.
    assign eff_rows = (i_num_rows == '0 || i_num_rows > CNT_W'(N_ELEM)) ? CNT_W'(N_ELEM)
                                                                        : i_num_rows;
    assign last_idx = IDX_W'(rows_q - 1'b1);

    assign vec_el  = vec_q[i_col_idx*DATA_W +: DATA_W];
    assign mat_val = i_mat_value;
    assign prod    = mat_val * vec_el;
    assign acc_sum = acc_q + {{(SUM_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        rows_d  = rows_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StAcc;
                    vec_d   = i_in_vector;
                    rows_d  = eff_rows;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            end
            StAcc: begin
                if (i_nnz_valid) begin
                    if (i_row_last) begin
                        sum_d   = acc_sum;
                        acc_d   = '0;
                        state_d = StOut;
                    end else begin
                        acc_d = acc_sum;
                    end
                end
            end
            StOut: begin
                if (i_row_ready) begin
                    if (idx_q == last_idx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StAcc;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            vec_q   <= '0;
            rows_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            rows_q  <= rows_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
        end
    end

    assign o_nnz_ready = (state_q == StAcc);
    assign o_row_valid = (state_q == StOut);
    assign o_busy      = (state_q != StIdle);
    assign o_done      = (state_q == StDone);
    assign o_row_sum   = sum_q;
    assign o_row_idx   = idx_q;

endmodule

// File: tb/tb_spmv_row_mac.sv
// Directed bench for spmv_row_mac: a table of single-row jobs plus hand-written
// sequences for multi-row, backpressure, extremes, clamping and reset corners.
module tb_spmv_row_mac;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] in_vector;
    logic [4:0]   num_rows;
    logic         nnz_valid;
    logic         nnz_ready;
    logic [15:0]  mat_value;
    logic [3:0]   col_idx;
    logic         row_last;
    logic         row_valid;
    logic         row_ready;
    logic [35:0]  row_sum;
    logic [3:0]   row_idx;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spmv_row_mac #(.DATA_W(16), .N_ELEM(16)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_in_vector(in_vector),
        .i_num_rows (num_rows),
        .i_nnz_valid(nnz_valid),
        .o_nnz_ready(nnz_ready),
        .i_mat_value(mat_value),
        .i_col_idx  (col_idx),
        .i_row_last (row_last),
        .o_row_valid(row_valid),
        .i_row_ready(row_ready),
        .o_row_sum  (row_sum),
        .o_row_idx  (row_idx),
        .o_busy     (busy),
        .o_done     (done)
    );

    typedef struct {
        int                n;
        logic [3:0][15:0]  vals;
        logic [3:0][3:0]   cols;
        logic [35:0]       exp;
    } row_vec_t;

    row_vec_t tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] inc_vec();
        logic [255:0] v;
        for (int k = 0; k < 16; k++) v[16*k +: 16] = 16'(k + 1);
        return v;
    endfunction

    // All stimulus is driven just after a falling edge.
    task automatic start_job(input logic [255:0] vec, input logic [4:0] nr);
        in_vector = vec;
        num_rows  = nr;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic send_nz(input logic [15:0] v, input logic [3:0] c, input logic last);
        int cnt = 0;
        nnz_valid = 1'b1;
        mat_value = v;
        col_idx   = c;
        row_last  = last;
        while (!nnz_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!nnz_ready) check("nnz_ready_timeout", 64'(nnz_ready), 64'(1));
        @(negedge clk);
        nnz_valid = 1'b0;
        row_last  = 1'b0;
    endtask

    task automatic wait_row(input string name, input logic [35:0] exp_sum, input logic [3:0] exp_idx);
        int cnt = 0;
        while (!row_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check({name, "_valid"}, 64'(row_valid), 64'(1));
        check({name, "_sum"}, 64'(row_sum), 64'(exp_sum));
        check({name, "_idx"}, 64'(row_idx), 64'(exp_idx));
        row_ready = 1'b1;
        @(negedge clk);
        row_ready = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cnt = 0;
        while (!done && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check({name, "_done"}, 64'(done), 64'(1));
        @(negedge clk);
        check({name, "_done_pulse"}, 64'(done), 64'(0));
        check({name, "_idle"}, 64'(busy), 64'(0));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_ready"}, 64'(nnz_ready), 64'(0));
        check({name, "_valid"}, 64'(row_valid), 64'(0));
        check({name, "_done"}, 64'(done), 64'(0));
        check({name, "_sum"}, 64'(row_sum), 64'(0));
        check({name, "_idx"}, 64'(row_idx), 64'(0));
    endtask

    initial begin
        // vec[k] = k+1 for every table row.
        tbl[0] = '{n: 1, vals: {16'h0, 16'h0, 16'h0, 16'h0001},
                   cols: {4'd0, 4'd0, 4'd0, 4'd0}, exp: 36'(1)};
        tbl[1] = '{n: 2, vals: {16'h0, 16'h0, 16'h0002, 16'hFFFF},
                   cols: {4'd0, 4'd0, 4'd3, 4'd15}, exp: 36'(-8)};
        tbl[2] = '{n: 4, vals: {16'h0001, 16'hFFCE, 16'd100, 16'd100},
                   cols: {4'd0, 4'd9, 4'd8, 4'd7}, exp: 36'(1201)};
        tbl[3] = '{n: 1, vals: {16'h0, 16'h0, 16'h0, 16'h0000},
                   cols: {4'd0, 4'd0, 4'd0, 4'd4}, exp: 36'(0)};
        tbl[4] = '{n: 2, vals: {16'h0, 16'h0, 16'h7FFF, 16'h7FFF},
                   cols: {4'd0, 4'd0, 4'd15, 4'd15}, exp: 36'(1048544)};

        rst = 1'b1; start = 1'b0; in_vector = '0; num_rows = '0;
        nnz_valid = 1'b0; mat_value = '0; col_idx = '0; row_last = 1'b0; row_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Two-row job, started on the first edge after reset release.
        start_job(inc_vec(), 5'd2);
        send_nz(16'd3, 4'd0, 1'b0);
        send_nz(16'd2, 4'd5, 1'b1);
        wait_row("two_row0", 36'(15), 4'd0);
        check("two_row_no_early_done", 64'(done), 64'(0));
        send_nz(16'hFFFC, 4'd15, 1'b1);
        wait_row("two_row1", 36'(-64), 4'd1);
        wait_done("two_row");

        for (int t = 0; t < 5; t++) begin
            start_job(inc_vec(), 5'd1);
            for (int j = 0; j < tbl[t].n; j++)
                send_nz(tbl[t].vals[j], tbl[t].cols[j], j == tbl[t].n - 1);
            check($sformatf("tbl%0d_latency", t), 64'(row_valid), 64'(1));
            wait_row($sformatf("tbl%0d", t), tbl[t].exp, 4'd0);
            wait_done($sformatf("tbl%0d", t));
        end

        // Backpressure: stall OUT for 5 cycles with a nonzero offered.
        start_job(inc_vec(), 5'd2);
        send_nz(16'd5, 4'd2, 1'b1);
        nnz_valid = 1'b1; mat_value = 16'd7; col_idx = 4'd1; row_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_valid", c), 64'(row_valid), 64'(1));
            check($sformatf("bp%0d_sum", c), 64'(row_sum), 64'(15));
            check($sformatf("bp%0d_idx", c), 64'(row_idx), 64'(0));
            check($sformatf("bp%0d_ready", c), 64'(nnz_ready), 64'(0));
            @(negedge clk);
        end
        nnz_valid = 1'b0;
        wait_row("bp_row0", 36'(15), 4'd0);
        send_nz(16'd1, 4'd0, 1'b1);
        wait_row("bp_row1", 36'(1), 4'd1);
        wait_done("bp");

        // Most-negative operands in every lane.
        start_job({16{16'h8000}}, 5'd1);
        for (int k = 0; k < 16; k++) send_nz(16'h8000, 4'(k), k == 15);
        wait_row("extreme", 36'h4_0000_0000, 4'd0);
        wait_done("extreme");

        // Full-depth jobs: 0 and an out-of-range count both mean 16 rows.
        for (int p = 0; p < 2; p++) begin
            start_job(inc_vec(), (p == 0) ? 5'd0 : 5'd31);
            for (int r = 0; r < 16; r++) begin
                send_nz(16'd0, 4'd0, 1'b1);
                wait_row($sformatf("full%0d_r%0d", p, r), 36'(0), 4'(r));
            end
            wait_done($sformatf("full%0d", p));
        end

        // Start pulse mid-job with a different vector and row count is ignored.
        start_job(inc_vec(), 5'd1);
        in_vector = {16{16'h0005}}; num_rows = 5'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_nz(16'd3, 4'd5, 1'b1);
        wait_row("midstart", 36'(18), 4'd0);
        wait_done("midstart");
        repeat (3) @(negedge clk);
        check("sum_hold_after_job", 64'(row_sum), 64'(18));

        // Reset during a partially accumulated row.
        start_job(inc_vec(), 5'd2);
        send_nz(16'd10, 4'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midreset");
        start_job(inc_vec(), 5'd1);
        send_nz(16'd1, 4'd1, 1'b1);
        wait_row("post_reset", 36'(2), 4'd0);
        wait_done("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spmv_row_mac.md
SPMV_ROW_MAC -- requirements
Module: spmv_row_mac

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of one signed vector element and one signed matrix value.
REQ-002 Parameter N_ELEM, default 16, SHALL set the number of elements in the input vector buffer and the maximum number of rows per job.
REQ-003 i_clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 i_rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 i_start  input  1  SHALL be a job-start pulse; it is honoured only in IDLE.
REQ-006 i_in_vector  input  256  SHALL carry the dense input vector; element k is bits [16k+15:16k].
REQ-007 i_num_rows  input  5  SHALL give the row count per job; 0 means 16, and values 17..31 are clamped to 16.
REQ-008 i_nnz_valid  input  1  SHALL qualify i_mat_value, i_col_idx and i_row_last.
REQ-009 o_nnz_ready  output  1  SHALL accept one nonzero per cycle when high.
REQ-010 i_mat_value  input  16  SHALL carry a signed nonzero matrix value.
REQ-011 i_col_idx  input  4  SHALL carry the column index of the value.
REQ-012 i_row_last  input  1  SHALL mark the final nonzero of the current row.
REQ-013 o_row_valid  output  1  SHALL qualify o_row_sum and o_row_idx.
REQ-014 i_row_ready  input  1  SHALL be the downstream acceptance of a row result.
REQ-015 o_row_sum  output  36  SHALL carry the signed row dot-product.
REQ-016 o_row_idx  output  4  SHALL carry the index of the current row, 0-based.
REQ-017 o_busy  output  1  SHALL be high in every state except IDLE.
REQ-018 o_done  output  1  SHALL pulse for one cycle at job end.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, ACC, OUT and DONE.
REQ-020 IDLE -> ACC SHALL occur on i_start; on that edge the block SHALL latch i_in_vector and the effective row count, and clear the accumulator and the row index.
REQ-021 o_nnz_ready SHALL be 1 only in ACC; a nonzero is transferred when i_nnz_valid and o_nnz_ready are both 1.
REQ-022 On each transfer, acc SHALL update to acc + sext(i_mat_value * vec[i_col_idx]), using a signed 16x16 -> 32-bit product sign-extended to 36 bits.
REQ-023 The 36-bit sum SHALL wrap on overflow, with no saturation.
REQ-024 A transfer with i_row_last=1 SHALL load o_row_sum with the final sum including that product, clear acc, and move ACC -> OUT; o_row_valid SHALL rise on the next cycle (latency 1 cycle).
REQ-025 In OUT, o_row_sum and o_row_idx SHALL stay stable and o_row_valid SHALL stay 1 until i_row_ready=1.
REQ-026 On the OUT handshake, if o_row_idx equals row count - 1 the FSM SHALL go to DONE; otherwise o_row_idx SHALL increment and the FSM SHALL return to ACC.
REQ-027 In DONE, o_done=1 for one cycle, then the FSM SHALL go to IDLE.
REQ-028 An empty row SHALL be sent as one transfer with i_mat_value=0 and i_row_last=1; the result is 0.
REQ-029 i_start outside IDLE SHALL be ignored, and the latched vector SHALL not change mid-job.
REQ-030 o_row_sum SHALL hold its last value after the job until the next row result is loaded.

Reset
REQ-031 With i_rst=1 at a clock edge, the block SHALL enter IDLE and clear acc, o_row_sum, o_row_idx, o_row_valid, o_nnz_ready, o_busy, o_done and the vector buffer to 0; this takes priority over all other inputs, including mid-job.
REQ-032 The first i_start SHALL be honoured on the first edge after i_rst deasserts.

Verification
REQ-033 Two-row job: vec[k]=k+1, num_rows=2; row0 nonzeros (3,col0),(2,col5 last); row1 (-4,col15 last) -> o_row_sum 15 then -64, o_row_idx 0 then 1, o_done once.
REQ-034 Backpressure: hold i_row_ready=0 for 5 cycles during OUT -> o_row_valid, o_row_sum and o_row_idx stay stable, o_nnz_ready=0, and no nonzero is consumed.
REQ-035 Extremes: vec all 0x8000, 16 nonzeros of 0x8000 in one row -> o_row_sum = 16*2^30 = 0x4_0000_0000, with no overflow.
REQ-036 num_rows=0 with 16 empty rows -> 16 results of 0, o_row_idx 0..15, o_done after row 15.
REQ-037 Assert i_rst while in ACC with a partial acc -> next cycle IDLE and all outputs 0; a new job then gives correct sums with no carry-over.
REQ-038 Pulse i_start mid-job with a different i_in_vector -> it is ignored, and results use the originally latched vector.
